// File: rtl/fsm_div_pkg.sv
// Shared definitions for the division-demo control FSM: state encodings,
// error codes and the default operand width.
package fsm_div_pkg;

  localparam int DEF_WIDTH = 4;

  // Encodings are visible on state_dbg, so they are fixed explicitly.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_B = 3'd1,
    S_START  = 3'd2,
    S_BUSY   = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ERR_NONE    = 4'd0,
    ERR_DIV0    = 4'd1,
    ERR_TIMEOUT = 4'd2
  } err_t;

endpackage

// File: rtl/fsm_div_ctrl_if.sv
// Handshake bundle between the control FSM (master) and the iterative
// divider datapath (slave).
interface fsm_div_ctrl_if
  import fsm_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  modport master (
    output div_start, div_a, div_b,
    input  div_done, div_q, div_r
  );

  modport slave (
    input  div_start, div_a, div_b,
    output div_done, div_q, div_r
  );

endinterface

// File: rtl/div_timeout_cnt.sv
// Loadable up-counter guarding the BUSY state. expired is asserted during
// the LIMIT-th consecutive enabled cycle after a clear.
module div_timeout_cnt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Count enabled cycles; clear has priority over counting.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/fsm_div_ctrl.sv
// Control FSM for the board-level division demo. Captures dividend and
// divisor on successive button strobes, screens out division by zero,
// handshakes with the divider and latches results for the display.
// Optional BUSY timeout abort is enabled by defining DIV_TIMEOUT_EN.
module fsm_div_ctrl
  import fsm_div_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_pulse,
  input  logic [WIDTH-1:0]     sw,
  fsm_div_ctrl_if.master       div_bus,
  output logic [WIDTH-1:0]     disp_op,
  output logic [WIDTH-1:0]     disp_res,
  output logic [WIDTH-1:0]     disp_rem,
  output logic [3:0]           err_code,
  output logic                 valid,
  output logic [2:0]           state_dbg
);

  state_t state;
  logic   timeout_hit;

`ifdef DIV_TIMEOUT_EN
  // The counter is cleared while in START, i.e. on entry to BUSY.
  div_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == S_START),
    .en      (state == S_BUSY),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign state_dbg = state;

  // Single registered FSM: state transitions and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      div_bus.div_start <= 1'b0;
      div_bus.div_a    <= '0;
      div_bus.div_b    <= '0;
      disp_op          <= '0;
      disp_res         <= '0;
      disp_rem         <= '0;
      err_code         <= ERR_NONE;
      valid            <= 1'b0;
    end else begin
      div_bus.div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (btn_pulse) begin
            div_bus.div_a <= sw;
            disp_op       <= sw;
            state         <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (btn_pulse) begin
            div_bus.div_b <= sw;
            disp_op       <= sw;
            if (sw == '0) begin
              // Divider is never started for a zero divisor.
              err_code <= ERR_DIV0;
              disp_res <= '0;
              disp_rem <= '0;
              valid    <= 1'b1;
              state    <= S_SHOW;
            end else begin
              div_bus.div_start <= 1'b1;
              state             <= S_START;
            end
          end
        end
        S_START: begin
          // A completion coincident with the start strobe is ignored.
          state <= S_BUSY;
        end
        S_BUSY: begin
          // A real completion wins over a simultaneous timeout expiry.
          if (div_bus.div_done) begin
            disp_res <= div_bus.div_q;
            disp_rem <= div_bus.div_r;
            err_code <= ERR_NONE;
            valid    <= 1'b1;
            state    <= S_SHOW;
          end else if (timeout_hit) begin
            disp_res <= '0;
            disp_rem <= '0;
            err_code <= ERR_TIMEOUT;
            valid    <= 1'b1;
            state    <= S_SHOW;
          end
        end
        S_SHOW: begin
          // Operands to the divider stay as they were; only the display
          // side is cleared for the next calculation.
          if (btn_pulse) begin
            disp_op  <= '0;
            disp_res <= '0;
            disp_rem <= '0;
            err_code <= ERR_NONE;
            valid    <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
